riscv_scoreboard: RTL

- Sequential register-hazard tracker on the producer side of the decode-stage hazard check.
- Per architectural register, counts outstanding in-flight writes: incremented when decode issues an instruction that writes rd, decremented when writeback retires it.
- Drives the decode stall from its own state instead of comparing rs against each pipeline stage's rd, so pipeline depth is free to grow.
- Sits between decode/issue and writeback.

---
 rtl/riscv_scoreboard.sv | 94 +++++++++
 1 files changed

// File: rtl/riscv_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters drive the decode stall.
// Optional macro RISCV_SCOREBOARD_BYPASS_EN lets a source whose last pending write retires this cycle skip the stall.
module riscv_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_we_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    output logic        stall_o,
    output logic        issue_o,
    output logic [31:0] busy_o,
    output logic        err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             err_q;
    logic             hz_rs1;
    logic             hz_rs2;
    logic             sat;
    logic             issue_wr;
    logic             retire;
    logic             err_set;
    logic [31:0]      inc_vec;
    logic [31:0]      dec_vec;

    always_comb begin
        hz_rs1 = (id_rs1_i != 5'd0) && (cnt_q[id_rs1_i] != '0);
        hz_rs2 = (id_rs2_i != 5'd0) && (cnt_q[id_rs2_i] != '0);
`ifdef RISCV_SCOREBOARD_BYPASS_EN
        // The register file/forwarding supplies a value whose last write retires now.
        if (wb_valid_i && (wb_rd_i == id_rs1_i) && (cnt_q[id_rs1_i] == CNT_ONE))
            hz_rs1 = 1'b0;
        if (wb_valid_i && (wb_rd_i == id_rs2_i) && (cnt_q[id_rs2_i] == CNT_ONE))
            hz_rs2 = 1'b0;
`endif
        sat = id_we_i && (id_rd_i != 5'd0) && (cnt_q[id_rd_i] == CNT_MAX);
    end

    assign stall_o  = id_valid_i & (hz_rs1 | hz_rs2 | sat);
    assign issue_o  = id_valid_i & ~stall_o;
    assign issue_wr = issue_o & id_we_i & (id_rd_i != 5'd0);
    assign retire   = wb_valid_i & (wb_rd_i != 5'd0);
    assign inc_vec  = issue_wr ? (32'd1 << id_rd_i) : 32'd0;
    assign dec_vec  = retire ? (32'd1 << wb_rd_i) : 32'd0;

    // An issue and a retire of the same register cancel, so no underflow is reported.
    always_comb begin
        cnt_d[0] = '0;
        for (int n = 1; n < 32; n++) begin
            cnt_d[n] = cnt_q[n];
            if (inc_vec[n] && !dec_vec[n])
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            else if (dec_vec[n] && !inc_vec[n] && (cnt_q[n] != '0))
                cnt_d[n] = cnt_q[n] - CNT_ONE;
        end
        err_set = retire && !inc_vec[wb_rd_i] && (cnt_q[wb_rd_i] == '0) && !flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int n = 0; n < 32; n++)
                cnt_q[n] <= '0;
            err_q <= 1'b0;
        end else if (flush_i) begin
            for (int n = 0; n < 32; n++)
                cnt_q[n] <= '0;
        end else begin
            for (int n = 0; n < 32; n++)
                cnt_q[n] <= cnt_d[n];
            if (err_set)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int n = 1; n < 32; n++)
            busy_o[n] = (cnt_q[n] != '0);
    end

    assign err_o = err_q;

endmodule
